// File: rtl/rtc_seq_pkg.sv
// Shared constants and types for the RTC register-bus sequencer.
package rtc_seq_pkg;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned ST_W   = 4;
   localparam int unsigned SEC_W  = 8;

   localparam logic [ADDR_W-1:0] ADDR_TIME_DEF = 5'h00;
   localparam logic [ADDR_W-1:0] ADDR_DATE_DEF = 5'h01;
   localparam logic [ADDR_W-1:0] ADDR_CMD_DEF  = 5'h04;

   localparam logic [DATA_W-1:0] CMD_UPDATE  = 32'h0000_0001;
   localparam logic [DATA_W-1:0] CMD_CAPTURE = 32'h0000_0002;

   // Sequencer states
   localparam logic [ST_W-1:0] ST_IDLE      = 4'd0;
   localparam logic [ST_W-1:0] ST_W_TIME    = 4'd1;
   localparam logic [ST_W-1:0] ST_W_DATE    = 4'd2;
   localparam logic [ST_W-1:0] ST_W_UPD     = 4'd3;
   localparam logic [ST_W-1:0] ST_W_CAP     = 4'd4;
   localparam logic [ST_W-1:0] ST_R_TIME    = 4'd5;
   localparam logic [ST_W-1:0] ST_R_DATE    = 4'd6;
   localparam logic [ST_W-1:0] ST_DONE_SET  = 4'd7;
   localparam logic [ST_W-1:0] ST_DONE_SNAP = 4'd8;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              wr;
      logic [DATA_W-1:0] wdata;
   } xfer_req_t;

endpackage

// File: rtl/rtc_bus_xfer.sv
// Single-transfer register-bus engine: owns the reg_* strobes and the ack timeout.
module rtc_bus_xfer
   import rtc_seq_pkg::*;
#(
   parameter int unsigned ACK_TMO = 16
) (
   input  logic        rtc_clk,
   input  logic        rst,
   input  logic        start,
   input  logic [4:0]  addr,
   input  logic        wr,
   input  logic [31:0] wdata,
   output logic        done_c,
   output logic        timeout_c,
   output logic [31:0] rdata_c,
   output logic        reg_cs,
   output logic [4:0]  reg_addr,
   output logic [31:0] reg_wdata,
   output logic [3:0]  reg_be,
   output logic        reg_wr,
   input  logic [31:0] reg_rdata,
   input  logic        reg_ack
);

   localparam int unsigned TMO_W = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TMO - 1);

   logic              cs_q, cs_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;

   always_ff @(posedge rtc_clk) begin
      if (rst) begin
         cs_q    <= 1'b0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         tmo_q   <= '0;
      end else begin
         cs_q    <= cs_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         tmo_q   <= tmo_d;
      end
   end

   // Strobes stay frozen while cs is up; cs always drops for a cycle after ack or timeout.
   always_comb begin
      cs_d      = cs_q;
      addr_d    = addr_q;
      wr_d      = wr_q;
      wdata_d   = wdata_q;
      tmo_d     = '0;
      done_c    = 1'b0;
      timeout_c = 1'b0;
      if (cs_q) begin
         if (reg_ack) begin
            cs_d   = 1'b0;
            done_c = 1'b1;
         end else if (tmo_q == TMO_LAST) begin
            cs_d      = 1'b0;
            timeout_c = 1'b1;
         end else begin
            tmo_d = tmo_q + TMO_W'(1);
         end
      end else if (start) begin
         cs_d    = 1'b1;
         addr_d  = addr;
         wr_d    = wr;
         wdata_d = wdata;
      end
   end

   assign rdata_c   = reg_rdata;
   assign reg_cs    = cs_q;
   assign reg_addr  = addr_q;
   assign reg_wr    = wr_q;
   assign reg_wdata = wdata_q;
   assign reg_be    = 4'hF;

endmodule

// File: rtl/rtc_seq_ctrl.sv
// RTC register sequencer: arbitrates host time/date set against coherent snapshots.
module rtc_seq_ctrl
   import rtc_seq_pkg::*;
#(
   parameter logic [4:0]  ADDR_TIME = ADDR_TIME_DEF,
   parameter logic [4:0]  ADDR_DATE = ADDR_DATE_DEF,
   parameter logic [4:0]  ADDR_CMD  = ADDR_CMD_DEF,
   parameter logic [7:0]  SNAP_SECS = 8'd60,
   parameter int unsigned ACK_TMO   = 16
) (
   input  logic        rtc_clk,
   input  logic        rst,
   input  logic        sec_tick,
   input  logic        set_req,
   input  logic [31:0] set_time,
   input  logic [31:0] set_date,
   output logic        set_ack,
   input  logic        snap_req,
   output logic        snap_valid,
   output logic [31:0] snap_time,
   output logic [31:0] snap_date,
   output logic        busy,
   output logic        err,
   output logic        reg_cs,
   output logic [4:0]  reg_addr,
   output logic [31:0] reg_wdata,
   output logic [3:0]  reg_be,
   output logic        reg_wr,
   input  logic [31:0] reg_rdata,
   input  logic        reg_ack
);

   logic [ST_W-1:0]   state_q, state_d;
   logic              issued_q, issued_d;
   logic [DATA_W-1:0] set_time_q, set_time_d;
   logic [DATA_W-1:0] set_date_q, set_date_d;
   logic [DATA_W-1:0] time_buf_q, time_buf_d;
   logic              snap_pend_q, snap_pend_d;
   logic [SEC_W-1:0]  sec_cnt_q, sec_cnt_d;
   logic              set_ack_q, set_ack_d;
   logic              snap_valid_q, snap_valid_d;
   logic [DATA_W-1:0] snap_time_q, snap_time_d;
   logic [DATA_W-1:0] snap_date_q, snap_date_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic              start_c;
   xfer_req_t         req_c;
   logic              done_c;
   logic              timeout_c;
   logic [DATA_W-1:0] rdata_c;
   logic              xfer_st_c;
   logic [ST_W-1:0]   nxt_st_c;
   logic              tick_hit_c;
   logic              pend_clr_c;
   logic [SEC_W-1:0]  sec_cnt_inc_c;

   rtc_bus_xfer #(
      .ACK_TMO (ACK_TMO)
   ) u_xfer (
      .rtc_clk   (rtc_clk),
      .rst       (rst),
      .start     (start_c),
      .addr      (req_c.addr),
      .wr        (req_c.wr),
      .wdata     (req_c.wdata),
      .done_c    (done_c),
      .timeout_c (timeout_c),
      .rdata_c   (rdata_c),
      .reg_cs    (reg_cs),
      .reg_addr  (reg_addr),
      .reg_wdata (reg_wdata),
      .reg_be    (reg_be),
      .reg_wr    (reg_wr),
      .reg_rdata (reg_rdata),
      .reg_ack   (reg_ack)
   );

   always_ff @(posedge rtc_clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         issued_q     <= 1'b0;
         set_time_q   <= '0;
         set_date_q   <= '0;
         time_buf_q   <= '0;
         snap_pend_q  <= 1'b0;
         sec_cnt_q    <= '0;
         set_ack_q    <= 1'b0;
         snap_valid_q <= 1'b0;
         snap_time_q  <= '0;
         snap_date_q  <= '0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         issued_q     <= issued_d;
         set_time_q   <= set_time_d;
         set_date_q   <= set_date_d;
         time_buf_q   <= time_buf_d;
         snap_pend_q  <= snap_pend_d;
         sec_cnt_q    <= sec_cnt_d;
         set_ack_q    <= set_ack_d;
         snap_valid_q <= snap_valid_d;
         snap_time_q  <= snap_time_d;
         snap_date_q  <= snap_date_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
      end
   end

   // Second counter; a zero period disables automatic snapshots.
   always_comb begin
      sec_cnt_d     = sec_cnt_q;
      tick_hit_c    = 1'b0;
      sec_cnt_inc_c = sec_cnt_q + SEC_W'(1);
      if (sec_tick && (SNAP_SECS != 8'd0)) begin
         if (sec_cnt_inc_c == SNAP_SECS) begin
            tick_hit_c = 1'b1;
            sec_cnt_d  = '0;
         end else begin
            sec_cnt_d  = sec_cnt_inc_c;
         end
      end
   end

   // Sequencing FSM; every bus state issues one transfer and advances on its ack.
   always_comb begin
      state_d      = state_q;
      issued_d     = issued_q;
      set_time_d   = set_time_q;
      set_date_d   = set_date_q;
      time_buf_d   = time_buf_q;
      set_ack_d    = 1'b0;
      snap_valid_d = 1'b0;
      snap_time_d  = snap_time_q;
      snap_date_d  = snap_date_q;
      err_d        = err_q;
      start_c      = 1'b0;
      pend_clr_c   = 1'b0;
      xfer_st_c    = 1'b0;
      nxt_st_c     = ST_IDLE;
      req_c.addr   = '0;
      req_c.wr     = 1'b0;
      req_c.wdata  = '0;

      case (state_q)
         ST_IDLE: begin
            if (set_req) begin
               state_d    = ST_W_TIME;
               set_time_d = set_time;
               set_date_d = set_date;
            end else if (snap_pend_q) begin
               state_d    = ST_W_CAP;
               pend_clr_c = 1'b1;
            end
         end
         ST_W_TIME: begin
            xfer_st_c   = 1'b1;
            nxt_st_c    = ST_W_DATE;
            req_c.addr  = ADDR_TIME;
            req_c.wr    = 1'b1;
            req_c.wdata = set_time_q;
         end
         ST_W_DATE: begin
            xfer_st_c   = 1'b1;
            nxt_st_c    = ST_W_UPD;
            req_c.addr  = ADDR_DATE;
            req_c.wr    = 1'b1;
            req_c.wdata = set_date_q;
         end
         ST_W_UPD: begin
            xfer_st_c   = 1'b1;
            nxt_st_c    = ST_DONE_SET;
            req_c.addr  = ADDR_CMD;
            req_c.wr    = 1'b1;
            req_c.wdata = CMD_UPDATE;
         end
         ST_W_CAP: begin
            xfer_st_c   = 1'b1;
            nxt_st_c    = ST_R_TIME;
            req_c.addr  = ADDR_CMD;
            req_c.wr    = 1'b1;
            req_c.wdata = CMD_CAPTURE;
         end
         ST_R_TIME: begin
            xfer_st_c  = 1'b1;
            nxt_st_c   = ST_R_DATE;
            req_c.addr = ADDR_TIME;
         end
         ST_R_DATE: begin
            xfer_st_c  = 1'b1;
            nxt_st_c   = ST_DONE_SNAP;
            req_c.addr = ADDR_DATE;
         end
         ST_DONE_SET:  state_d = ST_IDLE;
         ST_DONE_SNAP: state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase

      if (xfer_st_c) begin
         if (!issued_q) begin
            start_c  = 1'b1;
            issued_d = 1'b1;
         end else if (timeout_c) begin
            issued_d = 1'b0;
            err_d    = 1'b1;
            state_d  = ST_IDLE;
         end else if (done_c) begin
            issued_d = 1'b0;
            state_d  = nxt_st_c;
            if (state_q == ST_W_UPD) begin
               set_ack_d = 1'b1;
            end
            if (state_q == ST_R_TIME) begin
               time_buf_d = rdata_c;
            end
            // Both halves land in the same cycle so a partial snapshot is never visible.
            if (state_q == ST_R_DATE) begin
               snap_valid_d = 1'b1;
               snap_time_d  = time_buf_q;
               snap_date_d  = rdata_c;
            end
         end
      end

      snap_pend_d = (snap_pend_q && !pend_clr_c) || snap_req || tick_hit_c;
      busy_d      = (state_d != ST_IDLE);
   end

   assign set_ack    = set_ack_q;
   assign snap_valid = snap_valid_q;
   assign snap_time  = snap_time_q;
   assign snap_date  = snap_date_q;
   assign busy       = busy_q;
   assign err        = err_q;

endmodule

// File: tb/tb_rtc_seq_ctrl.sv
// Directed bench for rtc_seq_ctrl with a register-block responder and transfer log.
module tb_rtc_seq_ctrl;

   logic        rtc_clk = 1'b0;
   logic        rst, sec_tick, set_req, snap_req;
   logic [31:0] set_time, set_date;
   logic        set_ack, snap_valid, busy, err;
   logic [31:0] snap_time, snap_date;
   logic        reg_cs, reg_wr;
   logic [4:0]  reg_addr;
   logic [31:0] reg_wdata;
   logic [3:0]  reg_be;
   logic [31:0] reg_rdata = 32'h0;
   logic        reg_ack   = 1'b0;

   logic        b_set_ack, b_snap_valid, b_busy, b_err, b_cs, b_wr;
   logic [31:0] b_snap_time, b_snap_date, b_wdata;
   logic [4:0]  b_addr;
   logic [3:0]  b_be;
   logic        b_ack = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   always #5 rtc_clk = ~rtc_clk;

   rtc_seq_ctrl #(.SNAP_SECS(8'd3)) u_dut (
      .rtc_clk(rtc_clk), .rst(rst), .sec_tick(sec_tick),
      .set_req(set_req), .set_time(set_time), .set_date(set_date), .set_ack(set_ack),
      .snap_req(snap_req), .snap_valid(snap_valid), .snap_time(snap_time), .snap_date(snap_date),
      .busy(busy), .err(err), .reg_cs(reg_cs), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
      .reg_be(reg_be), .reg_wr(reg_wr), .reg_rdata(reg_rdata), .reg_ack(reg_ack)
   );

   rtc_seq_ctrl #(.SNAP_SECS(8'd0)) u_dut_off (
      .rtc_clk(rtc_clk), .rst(rst), .sec_tick(sec_tick),
      .set_req(1'b0), .set_time(32'h0), .set_date(32'h0), .set_ack(b_set_ack),
      .snap_req(1'b0), .snap_valid(b_snap_valid), .snap_time(b_snap_time), .snap_date(b_snap_date),
      .busy(b_busy), .err(b_err), .reg_cs(b_cs), .reg_addr(b_addr), .reg_wdata(b_wdata),
      .reg_be(b_be), .reg_wr(b_wr), .reg_rdata(32'h0), .reg_ack(b_ack)
   );

   // Register-block model: acks each transfer ack_lat+1 cycles after cs rises
   logic        ack_en = 1'b1;
   int          ack_lat = 1;
   int          wcnt = 0;
   int          nx = 0;
   logic [31:0] rd_time = 32'h0;
   logic [31:0] rd_date = 32'h0;
   logic [4:0]  lg_addr [0:63];
   logic        lg_wr   [0:63];
   logic [31:0] lg_data [0:63];
   logic [3:0]  lg_be   [0:63];

   always @(posedge rtc_clk) begin
      reg_ack <= 1'b0;
      b_ack   <= b_cs && !b_ack;
      if (rst) begin
         wcnt <= 0;
      end else if (reg_cs && !reg_ack && ack_en) begin
         if (wcnt == ack_lat) begin
            reg_ack   <= 1'b1;
            wcnt      <= 0;
            reg_rdata <= (reg_addr == 5'h00) ? rd_time :
                         (reg_addr == 5'h01) ? rd_date : 32'hDEAD_BEEF;
            lg_addr[nx % 64] <= reg_addr;
            lg_wr[nx % 64]   <= reg_wr;
            lg_data[nx % 64] <= reg_wdata;
            lg_be[nx % 64]   <= reg_be;
            nx <= nx + 1;
         end else begin
            wcnt <= wcnt + 1;
         end
      end else if (!reg_cs) begin
         wcnt <= 0;
      end
   end

   int n_ack = 0;
   int n_snap = 0;
   int b_nsnap = 0;
   int b_ncs = 0;

   always @(negedge rtc_clk) begin
      if (set_ack)      n_ack   = n_ack + 1;
      if (snap_valid)   n_snap  = n_snap + 1;
      if (b_snap_valid) b_nsnap = b_nsnap + 1;
      if (b_cs)         b_ncs   = b_ncs + 1;
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic chk_xfer(input string tag, input int idx, input logic [4:0] addr,
                           input logic wr, input logic [31:0] data);
      chk_eq({tag, "_addr"}, 64'(lg_addr[idx % 64]), 64'(addr));
      chk_eq({tag, "_wr"},   64'(lg_wr[idx % 64]),   64'(wr));
      chk_eq({tag, "_be"},   64'(lg_be[idx % 64]),   64'h0F);
      if (wr) chk_eq({tag, "_wdata"}, 64'(lg_data[idx % 64]), 64'(data));
   endtask

   // sel: 0 set_ack, 1 snap_valid, 2 idle, 3 cs up, 4 cs up on date address
   task automatic wait_on(input int sel, input string tag);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         @(negedge rtc_clk);
         case (sel)
            0: hit = set_ack;
            1: hit = snap_valid;
            2: hit = !busy;
            3: hit = reg_cs;
            default: hit = reg_cs && (reg_addr == 5'h01);
         endcase
      end
      chk_eq(tag, 64'(hit), 64'd1);
   endtask

   task automatic pulse_snap();
      @(negedge rtc_clk);
      snap_req = 1'b1;
      @(negedge rtc_clk);
      snap_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base, s0, a0, cnt;
      rst = 1'b1; sec_tick = 1'b0; set_req = 1'b0; snap_req = 1'b0;
      set_time = 32'h0; set_date = 32'h0;
      repeat (4) @(negedge rtc_clk);
      chk_eq("rst_cs",    64'(reg_cs),     64'd0);
      chk_eq("rst_busy",  64'(busy),       64'd0);
      chk_eq("rst_err",   64'(err),        64'd0);
      chk_eq("rst_ack",   64'(set_ack),    64'd0);
      chk_eq("rst_valid", 64'(snap_valid), 64'd0);
      chk_eq("rst_stime", 64'(snap_time),  64'd0);
      chk_eq("rst_sdate", 64'(snap_date),  64'd0);
      chk_eq("rst_be",    64'(reg_be),     64'h0F);
      rst = 1'b0;

      // Host set sequence
      base = nx;
      set_time = 32'h0012_3045; set_date = 32'h2022_1118;
      @(negedge rtc_clk);
      set_req = 1'b1;
      wait_on(0, "set_ack_seen");
      set_req = 1'b0;
      wait_on(2, "set_idle");
      chk_eq("set_nxfer", 64'(nx - base), 64'd3);
      chk_xfer("set_x0", base + 0, 5'h00, 1'b1, 32'h0012_3045);
      chk_xfer("set_x1", base + 1, 5'h01, 1'b1, 32'h2022_1118);
      chk_xfer("set_x2", base + 2, 5'h04, 1'b1, 32'h1);
      chk_eq("set_nack", 64'(n_ack), 64'd1);

      // Explicit snapshot
      base = nx;
      rd_time = 32'h0305_5959; rd_date = 32'h2022_1231;
      pulse_snap();
      wait_on(1, "snap_valid_seen");
      chk_eq("snap_time", 64'(snap_time), 64'h0305_5959);
      chk_eq("snap_date", 64'(snap_date), 64'h2022_1231);
      wait_on(2, "snap_idle");
      repeat (5) @(negedge rtc_clk);
      chk_eq("snap_nxfer", 64'(nx - base), 64'd3);
      chk_xfer("snap_x0", base + 0, 5'h04, 1'b1, 32'h2);
      chk_xfer("snap_x1", base + 1, 5'h00, 1'b0, 32'h0);
      chk_xfer("snap_x2", base + 2, 5'h01, 1'b0, 32'h0);
      chk_eq("snap_once", 64'(n_snap), 64'd1);

      // Periodic snapshots: 7 ticks with a 3-second period, and a disabled instance
      base = nx; s0 = n_snap;
      for (int k = 0; k < 7; k++) begin
         @(negedge rtc_clk); sec_tick = 1'b1;
         @(negedge rtc_clk); sec_tick = 1'b0;
         repeat (30) @(negedge rtc_clk);
      end
      chk_eq("auto_nsnap", 64'(n_snap - s0), 64'd2);
      chk_eq("auto_nxfer", 64'(nx - base), 64'd6);
      chk_eq("off_nsnap",  64'(b_nsnap), 64'd0);
      chk_eq("off_ncs",    64'(b_ncs), 64'd0);

      // Set and snapshot requested together: set first, then snapshot
      base = nx; s0 = n_snap;
      set_time = 32'h1111_2222; set_date = 32'h3333_4444;
      @(negedge rtc_clk);
      set_req = 1'b1; snap_req = 1'b1;
      @(negedge rtc_clk);
      snap_req = 1'b0;
      wait_on(0, "coll_set_ack");
      set_req = 1'b0;
      wait_on(1, "coll_snap");
      wait_on(2, "coll_idle");
      chk_eq("coll_nxfer", 64'(nx - base), 64'd6);
      chk_xfer("coll_x0", base + 0, 5'h00, 1'b1, 32'h1111_2222);
      chk_xfer("coll_x2", base + 2, 5'h04, 1'b1, 32'h1);
      chk_xfer("coll_x3", base + 3, 5'h04, 1'b1, 32'h2);
      chk_eq("coll_nsnap", 64'(n_snap - s0), 64'd1);

      // Three snapshot requests during a set coalesce into one
      s0 = n_snap; a0 = n_ack;
      @(negedge rtc_clk);
      set_req = 1'b1;
      @(negedge rtc_clk);
      for (int k = 0; k < 3; k++) begin
         repeat (2) @(negedge rtc_clk);
         snap_req = 1'b1;
         @(negedge rtc_clk);
         snap_req = 1'b0;
      end
      wait_on(0, "coal_set_ack");
      set_req = 1'b0;
      repeat (60) @(negedge rtc_clk);
      chk_eq("coal_nsnap", 64'(n_snap - s0), 64'd1);
      chk_eq("coal_nack",  64'(n_ack - a0), 64'd1);

      // Ack timeout: cs held 16 cycles, err sticky, no set_ack
      ack_en = 1'b0; a0 = n_ack;
      @(negedge rtc_clk);
      set_req = 1'b1;
      wait_on(3, "tmo_cs_up");
      set_req = 1'b0;
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
         @(negedge rtc_clk);
         if (reg_cs) cnt = cnt + 1;
         else break;
      end
      chk_eq("tmo_cs_cycles", 64'(cnt), 64'd16);
      chk_eq("tmo_err",  64'(err),  64'd1);
      chk_eq("tmo_busy", 64'(busy), 64'd0);
      ack_en = 1'b1;
      repeat (5) @(negedge rtc_clk);
      chk_eq("tmo_no_ack", 64'(n_ack - a0), 64'd0);
      rd_time = 32'h0102_0304; rd_date = 32'h2023_0101;
      pulse_snap();
      wait_on(1, "tmo_next_snap");
      chk_eq("tmo_next_time", 64'(snap_time), 64'h0102_0304);
      chk_eq("tmo_err_sticky", 64'(err), 64'd1);
      wait_on(2, "tmo_idle");

      // Reset during the date write
      @(negedge rtc_clk);
      set_req = 1'b1;
      wait_on(4, "rstm_wdate");
      rst = 1'b1; set_req = 1'b0;
      @(negedge rtc_clk);
      chk_eq("rstm_cs",    64'(reg_cs),    64'd0);
      chk_eq("rstm_busy",  64'(busy),      64'd0);
      chk_eq("rstm_stime", 64'(snap_time), 64'd0);
      chk_eq("rstm_sdate", 64'(snap_date), 64'd0);
      chk_eq("rstm_err",   64'(err),       64'd0);
      chk_eq("rstm_ack",   64'(set_ack),   64'd0);
      rst = 1'b0;
      repeat (5) @(negedge rtc_clk);
      chk_eq("rstm_quiet", 64'(busy), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
